// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: slot record, register-file forward select and select-width helper
package hazard_pkg;
   localparam int REG_W_MAX = 8;
   localparam int FWD_RF = 0;
   typedef struct packed {
      logic                 valid;
      logic                 regwrite;
      logic [REG_W_MAX-1:0] dest;
      logic                 isload;
   } slot_t;
   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: E/M-stage hazard inputs and forward/stall/flush results
interface hazard_scoreboard_if #(
   parameter int DEPTH    = 2,
   parameter int REG_BITS = 5,
   parameter int SELW     = hazard_pkg::sel_w(DEPTH)
);
   logic                ValidE;
   logic [REG_BITS-1:0] RsE;
   logic [REG_BITS-1:0] RtE;
   logic                UsesRsE;
   logic                UsesRtE;
   logic                RegWriteE;
   logic [REG_BITS-1:0] WriteRegE;
   logic                MemToRegE;
   logic                BranchTakenM;
   logic                MemWait;
   logic [SELW-1:0]     ForwardAE;
   logic [SELW-1:0]     ForwardBE;
   logic                StallE;
   logic                FlushE;
   logic [31:0]         StallCount;
   modport master (
      output ValidE, RsE, RtE, UsesRsE, UsesRtE, RegWriteE, WriteRegE, MemToRegE,
             BranchTakenM, MemWait,
      input  ForwardAE, ForwardBE, StallE, FlushE, StallCount
   );
   modport slave (
      input  ValidE, RsE, RtE, UsesRsE, UsesRtE, RegWriteE, WriteRegE, MemToRegE,
             BranchTakenM, MemWait,
      output ForwardAE, ForwardBE, StallE, FlushE, StallCount
   );
endinterface

// File: rtl/hazard_scoreboard_slot_match.sv
// hazard_slot_match: youngest-slot priority encoder for one E-stage operand
module hazard_slot_match import hazard_pkg::*; #(
   parameter int DEPTH     = 2,
   parameter int LOAD_SLOT = 1,
   parameter int REG_BITS  = 5,
   parameter int SELW      = sel_w(DEPTH)
) (
   input  slot_t [DEPTH:1]     i_slots,
   input  logic [REG_BITS-1:0] i_src,
   input  logic                i_uses,
   output logic [SELW-1:0]     o_sel,
   output logic                o_load_stall
);
   logic [REG_W_MAX-1:0] w_src;
   logic [SELW-1:0]      w_sel;
   logic                 w_load;
   assign w_src = REG_W_MAX'(i_src);
   // scan oldest to youngest so the lowest matching slot wins
   always_comb begin
      w_sel  = SELW'(FWD_RF);
      w_load = 1'b0;
      for (int k = DEPTH; k >= 1; k--)
         if (i_slots[k].valid && i_slots[k].regwrite && i_slots[k].dest == w_src &&
             w_src != '0 && i_uses) begin
            w_sel  = SELW'(k);
            w_load = i_slots[k].isload && (k < LOAD_SLOT);
         end
   end
   assign o_load_stall = w_load;
   assign o_sel        = w_load ? SELW'(FWD_RF) : w_sel;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer scoreboard driving forwarding, load-use stall and branch flush
module hazard_scoreboard import hazard_pkg::*; #(
   parameter int DEPTH     = 2,
   parameter int LOAD_SLOT = 1,
   parameter int REG_BITS  = 5,
   parameter int SELW      = sel_w(DEPTH)
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);
   slot_t [DEPTH:1] r_slots;
   logic [31:0]     r_count;
   logic [SELW-1:0] w_sel_a, w_sel_b;
   logic            w_ld_a, w_ld_b, w_flush, w_stall;
   hazard_slot_match #(.DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .REG_BITS(REG_BITS), .SELW(SELW)) u_match_a (
      .i_slots(r_slots), .i_src(bus.RsE), .i_uses(bus.UsesRsE), .o_sel(w_sel_a), .o_load_stall(w_ld_a)
   );
   hazard_slot_match #(.DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .REG_BITS(REG_BITS), .SELW(SELW)) u_match_b (
      .i_slots(r_slots), .i_src(bus.RtE), .i_uses(bus.UsesRtE), .o_sel(w_sel_b), .o_load_stall(w_ld_b)
   );
   // a taken branch outranks a load-use stall; memory wait outranks both
   always_comb begin
      w_flush = bus.BranchTakenM & ~bus.MemWait;
      w_stall = bus.MemWait | (~w_flush & (w_ld_a | w_ld_b));
   end
   assign bus.ForwardAE  = w_sel_a;
   assign bus.ForwardBE  = w_sel_b;
   assign bus.StallE     = w_stall;
   assign bus.FlushE     = w_flush;
   assign bus.StallCount = r_count;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slots <= '0;
         r_count <= '0;
      end else begin
         if (!bus.MemWait) begin
            r_slots[1] <= (bus.ValidE && !w_stall && !w_flush)
                        ? slot_t'{valid: 1'b1, regwrite: bus.RegWriteE,
                                  dest: REG_W_MAX'(bus.WriteRegE), isload: bus.MemToRegE}
                        : '0;
            for (int k = 2; k <= DEPTH; k++) r_slots[k] <= r_slots[k-1];
         end
         if (w_stall && r_count != '1) r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It tracks every register-writing instruction in flight past the E stage in a shift-register scoreboard of configurable depth, and drives per-operand forwarding selects for the E-stage ALU inputs. It generates load-use stalls for configurable load latency and the flush on a taken branch/jump resolved in M. It replaces the fixed single-bit ForwardAE/ForwardBE scheme and adds stall, flush and memory-wait handling.

## Interface
- DEPTH, 2, number of scoreboard slots after E (slot 1 = M); forwarding sources are slots 1..DEPTH
- LOAD_SLOT, 1, lowest slot index at which load data is forwardable; legal range 1..DEPTH
- REG_BITS, 5, register index width
- SELW, clog2(DEPTH+1), derived; forward-select width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ValidE  in  1  E stage holds a real instruction
- RsE, RtE  in  REG_BITS  E-stage source registers
- UsesRsE, UsesRtE  in  1  operand actually read by E instruction
- RegWriteE  in  1  E instruction writes a register
- WriteRegE  in  REG_BITS  E destination (after RegDst/JAL muxing)
- MemToRegE  in  1  E instruction is a load
- BranchTakenM  in  1  redirect resolved in M
- MemWait  in  1  memory not ready; freeze pipeline
- ForwardAE, ForwardBE  out  SELW  0 = register file, k = slot k result
- StallE  out  1  hold PC and I/E register
- FlushE  out  1  kill E instruction, invalidate I/E register
- StallCount  out  32  saturating count of cycles with StallE=1

## Operation
- Each slot holds: valid, regwrite, dest[REG_BITS-1:0], isload.
- Match for operand X in slot k requires all of: slot valid, regwrite, dest == X, dest != 0, UsesX.
- Forward select is the lowest k (youngest) that matches; 0 if none. x0 is never forwarded.
- Load-use hazard: youngest match is a load in slot k < LOAD_SLOT. This sets StallE=1 and the select for that operand = 0 (don't-care).
- FlushE = BranchTakenM & ~MemWait.
- Priority: flush over load-use stall.
  - Flush: StallE=0.
  - MemWait: StallE=1, FlushE=0.
- Slot update on edge when MemWait=0:
  - slot1 ← E info if ValidE & ~StallE & ~FlushE, else bubble (valid=0).
  - slot k+1 ← slot k.
  - Slot DEPTH retires; its value is in the register file from the next cycle, and the register file is write-before-read.
- When MemWait=1, all slots hold.
- StallCount increments on each cycle with StallE=1 and saturates at 0xFFFFFFFF.

## Timing
- ForwardAE/BE, StallE and FlushE are combinational from slot state and E inputs in the same cycle; there is no added latency.
- Scoreboard state changes only on clk rising edge.
- Reset: all slots invalid, StallCount=0; hence ForwardAE=ForwardBE=0, StallE=0, FlushE=0 (provided BranchTakenM=0).
- Load-use stall lasts exactly LOAD_SLOT−k cycles for a load in slot k, absent MemWait; each stalled cycle inserts one bubble.
- MemWait mid-stall: slots frozen, so stall duration is extended by the MemWait cycles and nothing is lost.
- BranchTakenM while MemWait=1: the flush is deferred until the first cycle with MemWait=0, because the branch remains in slot 1.
- Reset asserted mid-operation: all in-flight entries are discarded on that edge and StallCount clears.

## Structure
- hazard_pkg holds:
  - the slot record typedef;
  - the FWD_RF=0 constant;
  - the clog2-based SELW function.
- Sub-module hazard_slot_match: combinational priority encoder with one instance per operand. It takes the slot vector and one source register, and returns the select and the load-not-ready flag.
- Top level holds the slot shift register, the control priority logic and StallCount.

## Test plan
- Reset, then `add $3` followed by `add` using $3 as Rs (DEPTH=2) → ForwardAE=1 for one cycle, then ForwardAE=2, then 0.
- Two writers of $5 in slots 1 and 2, consumer reads $5 in both Rs and Rt → ForwardAE=ForwardBE=1 (youngest wins).
- LOAD_SLOT=2: `lw $4` followed immediately by a use of $4 → StallE=1 for 1 cycle with a bubble in slot 1, then ForwardAE=2, StallCount=1.
- Writer to $0 followed by a consumer of $0 → ForwardAE=0 and no stall.
- BranchTakenM=1 with MemWait=1 for 3 cycles → FlushE=0 and StallE=1 during the wait, then FlushE=1 on release, and slot 1 receives a bubble.
- LOAD_SLOT=3, load in slot 2 and BranchTakenM=1 in the same cycle → FlushE=1, StallE=0; reset on the next edge → all selects 0 and StallCount=0.
